// File: rtl/fnd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low {dp,g,f,e,d,c,b,a} with dp off.
package fnd_pkg;

    typedef enum logic {
        MODE_SEC_MSEC = 1'b0,
        MODE_HOUR_MIN = 1'b1
    } fnd_mode_e;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] COM_OFF   = 4'b1111;

    typedef struct packed {
        fnd_mode_e  mode;
        logic [6:0] msec;
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hour;
    } fnd_snap_t;

    // Anything above 15 saturates to 15, which still decodes to blank.
    function automatic logic [3:0] clamp4(input logic [6:0] v);
        return (v > 7'd15) ? 4'hF : v[3:0];
    endfunction

    function automatic logic [3:0] dig_ones(input logic [6:0] v);
        return clamp4(v % 7'd10);
    endfunction

    function automatic logic [3:0] dig_tens(input logic [6:0] v);
        return clamp4(v / 7'd10);
    endfunction

    function automatic logic [3:0] com_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational 4-bit value to active-low seven-segment pattern.
// Values 10..15 produce the blank pattern.
module seg_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] value,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Four-digit multiplexed FND scanner for sec.msec / hour.min display.
// Define FND_DOT_BLINK_EN to blink the digit-2 dot; otherwise it stays lit.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_mode,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             scan_tick;
    logic [1:0]       idx;
    logic             frame_start;
    fnd_snap_t        snap;

    logic [6:0]       lo_val;
    logic [6:0]       hi_val;
    logic [6:0]       pair;
    logic [3:0]       digit;
    logic [7:0]       seg;
    logic             dot_on;
    logic             dot_here;

    assign scan_tick   = (div_cnt == DIV_LAST);
    assign frame_start = scan_tick && (idx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else if (scan_tick) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Inputs are sampled once per frame so a frame never mixes two times.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap <= '0;
        end else if (frame_start) begin
            snap <= '{
                mode: fnd_mode_e'(sel_mode),
                msec: msec,
                sec:  sec,
                min:  min,
                hour: hour
            };
        end
    end

    always_comb begin
        lo_val = snap.msec;
        hi_val = {1'b0, snap.sec};
        unique case (snap.mode)
            MODE_SEC_MSEC: begin
                lo_val = snap.msec;
                hi_val = {1'b0, snap.sec};
            end
            MODE_HOUR_MIN: begin
                lo_val = {1'b0, snap.min};
                hi_val = {2'b00, snap.hour};
            end
        endcase
    end

    assign pair  = idx[1] ? hi_val : lo_val;
    assign digit = idx[0] ? dig_tens(pair) : dig_ones(pair);

    seg_decoder u_seg_decoder (
        .value (digit),
        .seg   (seg)
    );

`ifdef FND_DOT_BLINK_EN
    assign dot_on = (snap.mode == MODE_SEC_MSEC)
                  ? (snap.msec < 7'd50)
                  : (snap.sec < 6'd30);
`else
    assign dot_on = 1'b1;
`endif

    assign dot_here = (idx == 2'd2) && dot_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fnd_com  <= COM_OFF;
            fnd_data <= SEG_BLANK;
        end else begin
            fnd_com  <= com_sel(idx);
            fnd_data <= {seg[7] & ~dot_here, seg[6:0]};
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with SCAN_DIV = 4.
// Expected segment codes are hand-computed per scenario.
module tb_fnd_scan_ctrl;

`ifdef FND_DOT_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel_mode = 1'b0;
    logic [6:0] msec = '0;
    logic [5:0] sec = '0;
    logic [5:0] min = '0;
    logic [4:0] hour = '0;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;

    int n_checks = 0;
    int n_pass = 0;
    int pos = 0;

    logic [3:0] com_exp [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] exp_f [4];

    fnd_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .sel_mode (sel_mode),
        .msec     (msec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .fnd_com  (fnd_com),
        .fnd_data (fnd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        pos = (pos + 1) % 16;
    endtask

    task automatic sync_frame();
        step();
        while (pos != 15) step();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF)
                $display("FAIL reset_hold com=%b data=%h want 1111/ff",
                         fnd_com, fnd_data);
            else
                n_pass++;
        end
        rst = 1'b0;
        pos = 15;
        step();
        n_checks++;
        if (fnd_com !== 4'b1110 || fnd_data !== 8'hC0)
            $display("FAIL reset_release com=%b data=%h want 1110/c0",
                     fnd_com, fnd_data);
        else
            n_pass++;
    endtask

    task automatic test_scan_frame();
        sel_mode = 1'b0;
        msec = 7'd42;
        sec = 6'd17;
        exp_f = '{8'hC0, 8'hC0, 8'h40, 8'hC0};
        for (int i = 0; i < 15; i++) begin
            step();
            n_checks++;
            if (fnd_com !== com_exp[pos/4] || fnd_data !== exp_f[pos/4])
                $display("FAIL zero_frame pos=%0d com=%b data=%h want %b/%h",
                         pos, fnd_com, fnd_data,
                         com_exp[pos/4], exp_f[pos/4]);
            else
                n_pass++;
        end
        exp_f = '{8'hA4, 8'h99, 8'h78, 8'hF9};
        for (int i = 0; i < 16; i++) begin
            step();
            n_checks++;
            if (fnd_com !== com_exp[pos/4] || fnd_data !== exp_f[pos/4])
                $display("FAIL scan_frame pos=%0d com=%b data=%h want %b/%h",
                         pos, fnd_com, fnd_data,
                         com_exp[pos/4], exp_f[pos/4]);
            else
                n_pass++;
        end
    endtask

    task automatic test_mode_switch();
        exp_f = '{8'hA4, 8'h99, 8'h78, 8'hF9};
        for (int i = 0; i < 16; i++) begin
            step();
            n_checks++;
            if (fnd_com !== com_exp[pos/4] || fnd_data !== exp_f[pos/4])
                $display("FAIL mode_hold pos=%0d com=%b data=%h want %b/%h",
                         pos, fnd_com, fnd_data,
                         com_exp[pos/4], exp_f[pos/4]);
            else
                n_pass++;
            if (pos == 4) begin
                sel_mode = 1'b1;
                hour = 5'd5;
                min = 6'd9;
            end
        end
        exp_f = '{8'h90, 8'hC0, 8'h12, 8'hC0};
        for (int i = 0; i < 16; i++) begin
            step();
            n_checks++;
            if (fnd_com !== com_exp[pos/4] || fnd_data !== exp_f[pos/4])
                $display("FAIL mode_new pos=%0d com=%b data=%h want %b/%h",
                         pos, fnd_com, fnd_data,
                         com_exp[pos/4], exp_f[pos/4]);
            else
                n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        sel_mode = 1'b0;
        msec = 7'd120;
        sec = 6'd17;
        sync_frame();
        exp_f = '{8'hC0, 8'hFF, BLINK ? 8'hF8 : 8'h78, 8'hF9};
        for (int i = 0; i < 16; i++) begin
            step();
            n_checks++;
            if (fnd_com !== com_exp[pos/4] || fnd_data !== exp_f[pos/4])
                $display("FAIL out_of_range pos=%0d com=%b data=%h want %b/%h",
                         pos, fnd_com, fnd_data,
                         com_exp[pos/4], exp_f[pos/4]);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        while (pos != 8) step();
        n_checks++;
        if (fnd_com !== 4'b1011 || fnd_data !== (BLINK ? 8'hF8 : 8'h78))
            $display("FAIL mid_before com=%b data=%h want 1011/%h",
                     fnd_com, fnd_data, BLINK ? 8'hF8 : 8'h78);
        else
            n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF)
            $display("FAIL mid_async com=%b data=%h want 1111/ff",
                     fnd_com, fnd_data);
        else
            n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF)
                $display("FAIL mid_hold com=%b data=%h want 1111/ff",
                         fnd_com, fnd_data);
            else
                n_pass++;
        end
        rst = 1'b0;
        pos = 15;
        exp_f = '{8'hC0, 8'hC0, 8'h40, 8'hC0};
        for (int i = 0; i < 16; i++) begin
            step();
            n_checks++;
            if (fnd_com !== com_exp[pos/4] || fnd_data !== exp_f[pos/4])
                $display("FAIL mid_restart pos=%0d com=%b data=%h want %b/%h",
                         pos, fnd_com, fnd_data,
                         com_exp[pos/4], exp_f[pos/4]);
            else
                n_pass++;
        end
    endtask

    task automatic test_dot_digit2();
        sel_mode = 1'b0;
        msec = 7'd75;
        sec = 6'd17;
        sync_frame();
        exp_f = '{8'h92, 8'hF8, BLINK ? 8'hF8 : 8'h78, 8'hF9};
        for (int i = 0; i < 16; i++) begin
            step();
            n_checks++;
            if (fnd_com !== com_exp[pos/4] || fnd_data !== exp_f[pos/4])
                $display("FAIL dot_digit2 pos=%0d com=%b data=%h want %b/%h",
                         pos, fnd_com, fnd_data,
                         com_exp[pos/4], exp_f[pos/4]);
            else
                n_pass++;
        end
    endtask

    task automatic test_max_time();
        sel_mode = 1'b1;
        hour = 5'd23;
        min = 6'd59;
        sec = 6'd45;
        sync_frame();
        exp_f = '{8'h90, 8'h92, BLINK ? 8'hB0 : 8'h30, 8'hA4};
        for (int i = 0; i < 16; i++) begin
            step();
            n_checks++;
            if (fnd_com !== com_exp[pos/4] || fnd_data !== exp_f[pos/4])
                $display("FAIL max_time pos=%0d com=%b data=%h want %b/%h",
                         pos, fnd_com, fnd_data,
                         com_exp[pos/4], exp_f[pos/4]);
            else
                n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_scan_frame();
        test_mode_switch();
        test_out_of_range();
        test_reset_mid_frame();
        test_dot_digit2();
        test_max_time();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
